// File: rtl/instr_fetch_unit_if.sv
// Bus bundle for the instruction fetch unit.
//   master : fetch unit side (drives imem_req/imem_addr and the Instr/instr_pc/instr_valid
//            presentation, receives imem_ack/imem_rdata, instr_ready and the redirect)
//   slave  : environment side (instruction memory + consumer + branch logic)
interface instr_fetch_unit_if #(
  parameter int ADDR_W = 16
);
  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic              imem_ack;
  logic [15:0]       imem_rdata;
  logic [15:0]       Instr;
  logic [ADDR_W-1:0] instr_pc;
  logic              instr_valid;
  logic              instr_ready;
  logic              PCSrc;
  logic [ADDR_W-1:0] branch_target;

  modport master (
    output imem_req, imem_addr, Instr, instr_pc, instr_valid,
    input  imem_ack, imem_rdata, instr_ready, PCSrc, branch_target
  );

  modport slave (
    input  imem_req, imem_addr, Instr, instr_pc, instr_valid,
    output imem_ack, imem_rdata, instr_ready, PCSrc, branch_target
  );
endinterface

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: holds the fetch PC, issues single outstanding word reads
// to instruction memory over req/ack, buffers returned words in a small circular
// prefetch queue and presents the head as Instr/instr_pc. A redirect (PCSrc) flushes
// the queue and squashes any in-flight read.
// Ports:
//   clk    : clock, rising edge
//   reset  : asynchronous, active-low
//   bus    : instr_fetch_unit_if.master (imem req/addr/ack/rdata, Instr/instr_pc/
//            instr_valid/instr_ready, PCSrc/branch_target)
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | no read outstanding; issue when queue has room and no redirect
// WAIT    | read outstanding, data will be pushed on ack
// WAIT_SQ | read outstanding but squashed by a redirect; ack data dropped
module instr_fetch_unit #(
  parameter int                ADDR_W   = 16,
  parameter int                DEPTH    = 2,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input logic               clk,
  input logic               reset,
  instr_fetch_unit_if.master bus
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WAIT    = 2'd1,
    ST_WAIT_SQ = 2'd2
  } state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] fetch_pc;
  logic              req_q;
  logic [ADDR_W-1:0] addr_q;

  logic [15:0]       q_data [DEPTH];
  logic [ADDR_W-1:0] q_pc   [DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [CNT_W-1:0]  count;

  logic issue, push, pop, valid;

  assign valid = (count != '0);
  // Redirect has priority over everything: a same-cycle pop is discarded.
  assign pop   = valid && bus.instr_ready && !bus.PCSrc;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    issue     = 1'b0;
    push      = 1'b0;
    case (state)
      ST_IDLE: begin
        // count cannot rise while a read is pending, so checking room at issue is enough
        if (!bus.PCSrc && (count < DEPTH_C)) begin
          issue     = 1'b1;
          state_nxt = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (bus.imem_ack) begin
          push      = !bus.PCSrc;
          state_nxt = ST_IDLE;
        end else if (bus.PCSrc) begin
          state_nxt = ST_WAIT_SQ;
        end
      end
      ST_WAIT_SQ: begin
        if (bus.imem_ack) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Request is registered: rises the cycle after issue, falls the cycle after ack.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      req_q  <= 1'b0;
      addr_q <= '0;
    end else if (issue) begin
      req_q  <= 1'b1;
      addr_q <= fetch_pc;
    end else if ((state != ST_IDLE) && bus.imem_ack) begin
      req_q  <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)          fetch_pc <= RESET_PC;
    else if (bus.PCSrc)  fetch_pc <= bus.branch_target;
    else if (issue)      fetch_pc <= fetch_pc + ADDR_W'(1);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        q_data[i] <= '0;
        q_pc[i]   <= '0;
      end
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (bus.PCSrc) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        q_data[wr_ptr] <= bus.imem_rdata;
        q_pc[wr_ptr]   <= addr_q;
        wr_ptr         <= wr_ptr + PTR_W'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
      if (push && !pop)      count <= count + CNT_W'(1);
      else if (!push && pop) count <= count - CNT_W'(1);
    end
  end

  assign bus.imem_req    = req_q;
  assign bus.imem_addr   = addr_q;
  assign bus.instr_valid = valid;
  assign bus.Instr       = valid ? q_data[rd_ptr] : 16'h0000;
  assign bus.instr_pc    = valid ? q_pc[rd_ptr]   : '0;

endmodule
